// File: rtl/tri_row_scanner.sv
// Captures a packed triangular-array snapshot and streams it out row by row
// with a strictly-lower-triangular mask, popcount and upper-triangle flag.
module tri_row_scanner #(
    parameter int N_ROWS = 8,
    parameter int ROW_W  = 16,
    localparam int IDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
    localparam int POP_W = $clog2(ROW_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_ROWS*ROW_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IDX_W-1:0]          out_idx,
    output logic [ROW_W-1:0]          out_bits,
    output logic [POP_W-1:0]          out_pop,
    output logic                      out_upper_nz,
    output logic                      out_last,
    output logic                      busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDX_W-1:0]          r_row;
    logic [IDX_W-1:0]          w_row_nxt;
    logic [N_ROWS*ROW_W-1:0]   r_buf;
    logic [N_ROWS*ROW_W-1:0]   w_buf_nxt;
    logic [ROW_W-1:0]          w_row_bits;
    logic [ROW_W-1:0]          w_masked;
    logic [POP_W-1:0]          w_pop;
    logic                      w_upper;
    logic                      w_scan;
    logic                      w_at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    assign w_scan    = (r_state == SCAN);
    assign w_at_last = (r_row == IDX_W'(N_ROWS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_buf_nxt   = r_buf;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_buf_nxt   = in_data;
                    w_row_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (w_at_last) begin
                        w_row_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_row_nxt = r_row + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Row select, mask and popcount depend only on registered state,
    // so the presented row stays stable across stalls.
    always_comb begin
        w_row_bits = '0;
        w_masked   = '0;
        w_upper    = 1'b0;
        w_pop      = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (r_row == IDX_W'(r)) begin
                w_row_bits = r_buf[r*ROW_W +: ROW_W];
            end
        end
        for (int b = 0; b < ROW_W; b++) begin
            if (b < int'(r_row)) begin
                w_masked[b] = w_row_bits[b];
            end else begin
                w_upper = w_upper | w_row_bits[b];
            end
        end
        for (int b = 0; b < ROW_W; b++) begin
            w_pop = w_pop + POP_W'(w_masked[b]);
        end
    end

    assign in_ready     = !w_scan;
    assign out_valid    = w_scan;
    assign busy         = w_scan;
    assign out_idx      = r_row;
    assign out_bits     = w_scan ? w_masked : '0;
    assign out_pop      = w_scan ? w_pop : '0;
    assign out_upper_nz = w_scan & w_upper;
    assign out_last     = w_scan & w_at_last;

endmodule

// File: tb/tb_tri_row_scanner.sv
// Self-checking bench for tri_row_scanner: directed frames plus random
// snapshots and stalls, compared against a per-row arithmetic model.
module tb_tri_row_scanner;

    localparam int NR = 8;
    localparam int RW = 16;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [127:0]    in_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_idx;
    logic [15:0]     out_bits;
    logic [4:0]      out_pop;
    logic            out_upper_nz;
    logic            out_last;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    tri_row_scanner dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_idx      (out_idx),
        .out_bits     (out_bits),
        .out_pop      (out_pop),
        .out_upper_nz (out_upper_nz),
        .out_last     (out_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] row_of(input logic [127:0] s, input int r);
        return s[r*RW +: RW];
    endfunction

    function automatic logic [15:0] lower_mask(input int r);
        logic [31:0] m;
        m = (r >= RW) ? 32'hFFFF_FFFF : ((32'd1 << r) - 32'd1);
        return m[15:0];
    endfunction

    task automatic chk_row(input logic [127:0] s, input int r);
        logic [15:0] raw;
        logic [15:0] eb;
        raw = row_of(s, r);
        eb  = raw & lower_mask(r);
        chk($sformatf("valid r%0d", r), 32'(out_valid), 32'd1);
        chk($sformatf("in_ready r%0d", r), 32'(in_ready), 32'd0);
        chk($sformatf("busy r%0d", r), 32'(busy), 32'd1);
        chk($sformatf("idx r%0d", r), 32'(out_idx), 32'(r));
        chk($sformatf("bits r%0d", r), 32'(out_bits), 32'(eb));
        chk($sformatf("pop r%0d", r), 32'(out_pop), 32'($countones(eb)));
        chk($sformatf("upper r%0d", r), 32'(out_upper_nz),
            32'((raw & ~lower_mask(r)) != 16'h0));
        chk($sformatf("last r%0d", r), 32'(out_last), 32'(r == NR - 1));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, " valid"}, 32'(out_valid), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " idx"}, 32'(out_idx), 32'd0);
        chk({tag, " bits"}, 32'(out_bits), 32'd0);
        chk({tag, " pop"}, 32'(out_pop), 32'd0);
        chk({tag, " upper"}, 32'(out_upper_nz), 32'd0);
        chk({tag, " last"}, 32'(out_last), 32'd0);
    endtask

    task automatic capture(input logic [127:0] s);
        in_valid = 1'b1;
        in_data  = s;
        tick();
        in_valid = 1'b0;
    endtask

    // Scan all rows; stall_row/stall_n force a fixed stall, rnd adds random ones.
    task automatic scan(input logic [127:0] s, input int stall_row,
                        input int stall_n, input bit rnd);
        int ns;
        for (int r = 0; r < NR; r++) begin
            ns = (r == stall_row) ? stall_n : 0;
            if (rnd) ns = ns + int'($urandom_range(0, 2));
            out_ready = 1'b0;
            for (int k = 0; k < ns; k++) begin
                chk_row(s, r);
                tick();
            end
            out_ready = 1'b1;
            chk_row(s, r);
            tick();
        end
        out_ready = 1'b0;
    endtask

    function automatic logic [127:0] rand_snap();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    logic [127:0] snap_a;
    logic [127:0] snap_b;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("post-reset");

        capture({128{1'b1}});
        scan({128{1'b1}}, -1, 0, 1'b0);
        chk_idle("ones bubble");

        capture('0);
        scan('0, -1, 0, 1'b0);
        chk_idle("zeros bubble");

        snap_a = '0;
        snap_a[7*RW +: RW] = 16'h007F;
        capture(snap_a);
        scan(snap_a, -1, 0, 1'b0);
        snap_a[7*RW +: RW] = 16'h0080;
        capture(snap_a);
        scan(snap_a, -1, 0, 1'b0);

        capture({128{1'b1}});
        scan({128{1'b1}}, 2, 3, 1'b0);
        chk_idle("stall bubble");

        capture({128{1'b1}});
        out_ready = 1'b1;
        repeat (4) tick();
        chk("pre-reset idx", 32'(out_idx), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async reset");
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        chk_idle("after reset");
        snap_a = '0;
        snap_a[1*RW +: RW] = 16'hFFFF;
        capture(snap_a);
        scan(snap_a, -1, 0, 1'b0);

        snap_a = rand_snap();
        snap_b = ~snap_a;
        in_valid = 1'b1;
        in_data  = snap_a;
        tick();
        in_data = snap_b;
        scan(snap_a, -1, 0, 1'b0);
        chk("b2b bubble in_ready", 32'(in_ready), 32'd1);
        chk("b2b bubble busy", 32'(busy), 32'd0);
        tick();
        in_valid = 1'b0;
        scan(snap_b, -1, 0, 1'b0);
        chk_idle("b2b end");

        for (int f = 0; f < 20; f++) begin
            snap_a = rand_snap();
            capture(snap_a);
            scan(snap_a, -1, 0, 1'b1);
        end
        chk_idle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_row_scanner.md
Name: tri_row_scanner

Overview:
- Downstream consumer of the 128-bit packed triangular-array output of the nonblocking-loop array register stage.
- Captures one 128-bit snapshot, which holds rows 0..7, each 16 bits wide.
- Streams the snapshot out one row per handshake, with a strictly-lower-triangular mask, a popcount, and an upper-triangle violation flag.
- Used in the cosim harness to serialise and check the array contents row by row.

Parameters:
- N_ROWS, 8, number of rows in the snapshot.
- ROW_W, 16, bits per row; in_data width = N_ROWS*ROW_W.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  snapshot available.
- in_ready  output  1  block can accept a snapshot.
- in_data  input  N_ROWS*ROW_W  packed rows; row r = in_data[r*ROW_W +: ROW_W].
- out_valid  output  1  row output valid.
- out_ready  input  1  consumer accepts the row.
- out_idx  output  max(1,$clog2(N_ROWS))  index of the presented row.
- out_bits  output  ROW_W  row bits with bits b>=out_idx forced to 0.
- out_pop  output  $clog2(ROW_W+1)  number of ones in out_bits.
- out_upper_nz  output  1  any bit b>=out_idx set in the raw row (triangularity violation).
- out_last  output  1  out_idx == N_ROWS-1.
- busy  output  1  high in SCAN state.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, row counter=0, snapshot buffer=0, in_ready=1, out_valid=0, out_idx=0, out_bits=0, out_pop=0, out_upper_nz=0, out_last=0, busy=0.
- States: IDLE and SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at posedge: latch in_data into the buffer, set row=0, go to SCAN.
- SCAN:
  - in_ready=0, out_valid=1, busy=1.
  - Outputs are a combinational function of registered buffer and row only, so they are stable while stalled.
  - Handshake (out_valid & out_ready at posedge) when out_last=0: row <= row+1.
  - Handshake when out_last=1: go to IDLE, row <= 0; the buffer retains its value.
  - No handshake: hold everything.
- Latency: snapshot accepted at edge k → row 0 presented in the cycle after edge k.
- Throughput: minimum N_ROWS+1 cycles per frame. There is one IDLE bubble cycle after the last row handshake, and no overlap of capture and scan.
- Mask rule: out_bits[b] = buf_row[b] & (b < row).
  - Row 0 always yields out_bits=0 and out_pop=0.
  - Bits b >= ROW_W never exist; if N_ROWS > ROW_W, rows with idx >= ROW_W pass all bits.
- out_pop: unsigned, zero-extended; maximum value min(row, ROW_W), which fits the declared width.
- out_upper_nz: OR of buf_row[b] for b >= row, within ROW_W.
- in_data is ignored while in SCAN, regardless of in_valid.
- Outputs while out_valid=0: out_bits/out_pop/out_upper_nz/out_last are driven 0. out_idx reflects the row counter, which is 0.
- Reset mid-operation: state, counter and buffer clear immediately (asynchronous), and out_valid drops without waiting for the clock. After rst deasserts, in_ready=1 and the first edge with in_valid captures a fresh snapshot.
- Simultaneous in_valid and a last-row handshake: in_valid is not accepted in that cycle, because in_ready=0. It is accepted on the following edge if still asserted.

Test Plan:
- All-ones snapshot, out_ready held 1 → 8 rows over 8 cycles:
  - row r: out_bits = (1<<r)-1, out_pop = r, out_upper_nz = 1;
  - out_last only at r=7; busy drops the cycle after.
- All-zeros snapshot → every row out_bits=0, out_pop=0, out_upper_nz=0; idx 0..7 in order.
- Row 7 cases:
  - row 7 = 16'h007F, others 0 → at idx 7: out_bits=16'h007F, out_pop=7, out_upper_nz=0;
  - repeat with row 7 = 16'h0080 → out_bits=0, out_pop=0, out_upper_nz=1.
- Backpressure: all-ones snapshot, out_ready=0 for 3 cycles while idx=2 → idx stays 2, out_bits=16'h0003 and out_pop=2 stable; advance to idx 3 on the first out_ready=1 edge.
- Reset mid-scan: assert rst asynchronously while idx=4 → out_valid=0 and in_ready=1 before the next edge. After release, a new snapshot with row 1 = 16'hFFFF gives idx1 out_bits=16'h0001, out_pop=1, out_upper_nz=1.
- Back-to-back: in_valid held high with two distinct snapshots → second captured exactly one cycle after the last-row handshake of the first; first-frame contents never leak into second-frame rows.
